// File: rtl/tile_dispatcher_pkg.sv
// tile_dispatcher_pkg: shared widths, record types and fixed-point helpers for the tile walker
`ifndef TILE_WIDTH_BITS
`define TILE_WIDTH_BITS 2
`endif
`ifndef TILE_COLUMNS_BITS
`define TILE_COLUMNS_BITS 5
`endif
`ifndef TILE_ROWS_BITS
`define TILE_ROWS_BITS 5
`endif

package tile_dispatcher_pkg;
  localparam int TILE_WIDTH_BITS = `TILE_WIDTH_BITS;
  localparam int TX_BITS = `TILE_COLUMNS_BITS;
  localparam int TY_BITS = `TILE_ROWS_BITS;
  localparam int FX_TOTAL_BITS = 16;
  localparam int FX_FRAC_BITS = 8;
  localparam int COLOR_BITS = 8;
  localparam int EW = 2 * FX_TOTAL_BITS;

  typedef logic signed [FX_TOTAL_BITS-1:0] fx_t;
  typedef logic signed [EW-1:0] efx_t;
  typedef logic [COLOR_BITS-1:0] color_t;
  typedef logic [TX_BITS-1:0] tx_t;
  typedef logic [TY_BITS-1:0] ty_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } coord_3d_t;

  typedef struct packed {
    color_t color;
    tx_t tile_x;
    ty_t tile_y;
  } metadata_t;

  typedef struct packed {
    efx_t [2:0] edges;
    coord_3d_t [2:0] deltas;
    fx_t dzdx;
    fx_t dzdy;
    efx_t z;
    color_t color;
    tx_t bb_x0;
    tx_t bb_x1;
    ty_t bb_y0;
    ty_t bb_y1;
  } tile_setup_t;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  // Tile index to fixed-point pixel position of the tile's top-left corner
  function automatic coord_3d_t tile_coord_to_abs(tx_t tx, ty_t ty);
    coord_3d_t c;
    c.x = fx_t'(tx) << (TILE_WIDTH_BITS + FX_FRAC_BITS);
    c.y = fx_t'(ty) << (TILE_WIDTH_BITS + FX_FRAC_BITS);
    c.z = '0;
    return c;
  endfunction

  // Per-pixel gradient widened to the accumulator format and scaled to one tile step
  function automatic efx_t sext_fx_step(fx_t v);
    return efx_t'(v) <<< (FX_FRAC_BITS + TILE_WIDTH_BITS);
  endfunction
endpackage

// File: rtl/tile_edge_stepper.sv
// tile_edge_stepper: row-start and current accumulator for one edge function or z
module tile_edge_stepper
  import tile_dispatcher_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  efx_t load_val,
  input  efx_t step_x,
  input  efx_t step_y,
  input  logic advance_x,
  input  logic advance_row,
  output efx_t value
);
  efx_t row_start;

  // Load at setup, step right within a row, or move the row start down and restart from it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_start <= '0;
      value <= '0;
    end else if (load) begin
      row_start <= load_val;
      value <= load_val;
    end else if (advance_row) begin
      row_start <= row_start + step_y;
      value <= row_start + step_y;
    end else if (advance_x)
      value <= value + step_x;
endmodule

// File: rtl/tile_dispatcher.sv
// tile_dispatcher: walks a triangle's tile bounding box row-major, emitting per-tile start values
module tile_dispatcher
  import tile_dispatcher_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  output logic rdy_in,
  input  efx_t in_edge_0,
  input  efx_t in_edge_1,
  input  efx_t in_edge_2,
  input  coord_3d_t in_delta_0,
  input  coord_3d_t in_delta_1,
  input  coord_3d_t in_delta_2,
  input  fx_t in_dzdx,
  input  fx_t in_dzdy,
  input  efx_t in_z,
  input  color_t in_color,
  input  tx_t in_bb_x0,
  input  tx_t in_bb_x1,
  input  ty_t in_bb_y0,
  input  ty_t in_bb_y1,
  input  logic rdy_out,
  output logic vld_out,
  output coord_3d_t out_abs_pos,
  output coord_3d_t out_delta_0,
  output coord_3d_t out_delta_1,
  output coord_3d_t out_delta_2,
  output efx_t out_edge_0,
  output efx_t out_edge_1,
  output efx_t out_edge_2,
  output fx_t out_dzdx,
  output fx_t out_dzdy,
  output efx_t out_z_current,
  output metadata_t out_metadata,
  output logic busy,
  output logic done
);
  tile_setup_t in_setup;
  state_t state, state_nx;
  coord_3d_t [2:0] deltas;
  fx_t dzdx, dzdy;
  color_t color;
  tx_t bb_x0, bb_x1, tx;
  ty_t bb_y1, ty;
  efx_t [2:0] edge_cur;
  efx_t z_cur;
  logic accept, degen, hs, last_x, last_y, adv_x, adv_row, fin;

  assign in_setup = '{edges: {in_edge_2, in_edge_1, in_edge_0},
                      deltas: {in_delta_2, in_delta_1, in_delta_0},
                      dzdx: in_dzdx, dzdy: in_dzdy, z: in_z, color: in_color,
                      bb_x0: in_bb_x0, bb_x1: in_bb_x1, bb_y0: in_bb_y0, bb_y1: in_bb_y1};

  assign accept = state == IDLE && vld_in;
  assign degen = in_setup.bb_x1 < in_setup.bb_x0 || in_setup.bb_y1 < in_setup.bb_y0;
  assign hs = state == ISSUE && rdy_out;
  assign last_x = tx == bb_x1;
  assign last_y = ty == bb_y1;
  assign adv_x = hs && !last_x;
  assign adv_row = hs && last_x && !last_y;
  assign fin = hs && last_x && last_y;

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // Next state: a degenerate box is accepted but never leaves IDLE; each handshake inserts one gap cycle
  always_comb begin
    state_nx = state == IDLE  ? (accept && !degen ? ISSUE : IDLE) :
               state == ISSUE ? (hs ? (fin ? IDLE : GAP) : ISSUE) :
                                ISSUE;
  end

  // FSM outputs
  always_comb begin
    rdy_in = state == IDLE;
    busy = state != IDLE;
    vld_out = state == ISSUE;
  end

  // Setup latch, tile cursor and done pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deltas <= '0;
      dzdx <= '0;
      dzdy <= '0;
      color <= '0;
      bb_x0 <= '0;
      bb_x1 <= '0;
      bb_y1 <= '0;
      tx <= '0;
      ty <= '0;
      done <= 1'b0;
    end else begin
      done <= (accept && degen) || fin;
      if (accept) begin
        deltas <= in_setup.deltas;
        dzdx <= in_setup.dzdx;
        dzdy <= in_setup.dzdy;
        color <= in_setup.color;
        bb_x0 <= in_setup.bb_x0;
        bb_x1 <= in_setup.bb_x1;
        bb_y1 <= in_setup.bb_y1;
        tx <= in_setup.bb_x0;
        ty <= in_setup.bb_y0;
      end else if (adv_x)
        tx <= tx + tx_t'(1);
      else if (adv_row) begin
        tx <= bb_x0;
        ty <= ty + ty_t'(1);
      end
    end

  // Edge function E = a*x + b*y + c with delta.y as the x gradient and -delta.x as the y gradient
  for (genvar i = 0; i < 3; i++) begin : g_edge
    tile_edge_stepper u_step (
      .clk(clk),
      .rst_n(rst_n),
      .load(accept),
      .load_val(in_setup.edges[i]),
      .step_x(sext_fx_step(deltas[i].y)),
      .step_y(-sext_fx_step(deltas[i].x)),
      .advance_x(adv_x),
      .advance_row(adv_row),
      .value(edge_cur[i])
    );
  end

  tile_edge_stepper u_z (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .load_val(in_setup.z),
    .step_x(sext_fx_step(dzdx)),
    .step_y(sext_fx_step(dzdy)),
    .advance_x(adv_x),
    .advance_row(adv_row),
    .value(z_cur)
  );

  assign out_abs_pos = tile_coord_to_abs(tx, ty);
  assign out_delta_0 = deltas[0];
  assign out_delta_1 = deltas[1];
  assign out_delta_2 = deltas[2];
  assign out_edge_0 = edge_cur[0];
  assign out_edge_1 = edge_cur[1];
  assign out_edge_2 = edge_cur[2];
  assign out_dzdx = dzdx;
  assign out_dzdy = dzdy;
  assign out_z_current = z_cur;
  assign out_metadata = '{color: color, tile_x: tx, tile_y: ty};
endmodule

// File: tb/tb_tile_dispatcher.sv
// tb_tile_dispatcher: directed and randomized tile walks checked against a closed-form reference
module tb_tile_dispatcher;
  import tile_dispatcher_pkg::*;

  localparam longint S = 64'sd1 << (FX_FRAC_BITS + TILE_WIDTH_BITS);

  typedef struct packed {
    coord_3d_t abs_pos;
    efx_t e0, e1, e2;
    coord_3d_t d0, d1, d2;
    fx_t dzdx, dzdy;
    efx_t z;
    metadata_t meta;
  } rec_t;

  logic clk = 0, rst_n = 0, vld_in = 0, rdy_out = 1;
  logic rdy_in, vld_out, busy, done;
  efx_t d_e0 = '0, d_e1 = '0, d_e2 = '0, d_z = '0;
  coord_3d_t d_del0 = '0, d_del1 = '0, d_del2 = '0;
  fx_t d_dzdx = '0, d_dzdy = '0;
  color_t d_col = '0;
  tx_t d_x0 = '0, d_x1 = '0;
  ty_t d_y0 = '0, d_y1 = '0;
  coord_3d_t o_abs, o_d0, o_d1, o_d2;
  efx_t o_e0, o_e1, o_e2, o_z;
  fx_t o_dzdx, o_dzdy;
  metadata_t o_meta;
  rec_t dut_r;

  efx_t m_e[3];
  coord_3d_t m_d[3];
  fx_t m_dzdx, m_dzdy;
  efx_t m_z;
  color_t m_col;
  int m_x0, m_x1, m_y0, m_y1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  tile_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
    .in_edge_0(d_e0), .in_edge_1(d_e1), .in_edge_2(d_e2),
    .in_delta_0(d_del0), .in_delta_1(d_del1), .in_delta_2(d_del2),
    .in_dzdx(d_dzdx), .in_dzdy(d_dzdy), .in_z(d_z), .in_color(d_col),
    .in_bb_x0(d_x0), .in_bb_x1(d_x1), .in_bb_y0(d_y0), .in_bb_y1(d_y1),
    .rdy_out(rdy_out), .vld_out(vld_out), .out_abs_pos(o_abs),
    .out_delta_0(o_d0), .out_delta_1(o_d1), .out_delta_2(o_d2),
    .out_edge_0(o_e0), .out_edge_1(o_e1), .out_edge_2(o_e2),
    .out_dzdx(o_dzdx), .out_dzdy(o_dzdy), .out_z_current(o_z),
    .out_metadata(o_meta), .busy(busy), .done(done)
  );

  assign dut_r = {o_abs, o_e0, o_e1, o_e2, o_d0, o_d1, o_d2, o_dzdx, o_dzdy, o_z, o_meta};

  // Expected record for the idx-th tile: value = start + (#columns right)*x-step + (#rows down)*y-step
  function automatic rec_t model(int idx);
    rec_t r;
    int w = m_x1 - m_x0 + 1;
    longint cx = longint'(idx % w);
    longint cy = longint'(idx / w);
    efx_t ee[3];
    for (int k = 0; k < 3; k++)
      ee[k] = efx_t'(longint'(m_e[k]) + cx * longint'(m_d[k].y) * S - cy * longint'(m_d[k].x) * S);
    r.abs_pos.x = fx_t'((longint'(m_x0) + cx) * S);
    r.abs_pos.y = fx_t'((longint'(m_y0) + cy) * S);
    r.abs_pos.z = '0;
    r.e0 = ee[0];
    r.e1 = ee[1];
    r.e2 = ee[2];
    r.d0 = m_d[0];
    r.d1 = m_d[1];
    r.d2 = m_d[2];
    r.dzdx = m_dzdx;
    r.dzdy = m_dzdy;
    r.z = efx_t'(longint'(m_z) + cx * longint'(m_dzdx) * S + cy * longint'(m_dzdy) * S);
    r.meta = '{color: m_col, tile_x: tx_t'(longint'(m_x0) + cx), tile_y: ty_t'(longint'(m_y0) + cy)};
    return r;
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(efx_t e0, efx_t e1, efx_t e2, fx_t dx, fx_t dy, fx_t zx, fx_t zy, efx_t z);
    m_e[0] = e0;
    m_e[1] = e1;
    m_e[2] = e2;
    for (int k = 0; k < 3; k++) m_d[k] = '{x: dx, y: dy, z: fx_t'(k)};
    m_dzdx = zx;
    m_dzdy = zy;
    m_z = z;
    m_col = color_t'($urandom);
  endtask

  task automatic send(int x0, int x1, int y0, int y1);
    m_x0 = x0;
    m_x1 = x1;
    m_y0 = y0;
    m_y1 = y1;
    d_e0 = m_e[0];
    d_e1 = m_e[1];
    d_e2 = m_e[2];
    d_del0 = m_d[0];
    d_del1 = m_d[1];
    d_del2 = m_d[2];
    d_dzdx = m_dzdx;
    d_dzdy = m_dzdy;
    d_z = m_z;
    d_col = m_col;
    d_x0 = tx_t'(x0);
    d_x1 = tx_t'(x1);
    d_y0 = ty_t'(y0);
    d_y1 = ty_t'(y1);
    vld_in = 1;
    chk("rdy_in_idle", rdy_in, 1);
    tick();
    vld_in = 0;
  endtask

  // Consume records; optionally stall rdy_out at one tile, hit reset at one tile, or jiggle setup inputs
  task automatic collect(string tag, int stall_at, int stall_len, int abort_at, bit noise);
    int n = (m_x1 - m_x0 + 1) * (m_y1 - m_y0 + 1);
    int idx = 0, rem = stall_len, cyc = 0;
    bit was_stall = 0;
    while (idx < n && cyc < 400) begin
      if (was_stall) chk($sformatf("%s_stall_vld%0d", tag, idx), vld_out, 1);
      was_stall = 0;
      if (abort_at == idx && vld_out) begin
        rst_n = 0;
        #1;
        chk("abort_vld_out", vld_out, 0);
        chk("abort_rdy_in", rdy_in, 1);
        chk("abort_busy", busy, 0);
        vld_in = 0;
        rdy_out = 1;
        tick();
        rst_n = 1;
        tick();
        chk("abort_no_done", done, 0);
        chk("abort_idle_vld", vld_out, 0);
        return;
      end
      chk($sformatf("%s_busy%0d", tag, idx), busy, 1);
      chk($sformatf("%s_nodone%0d", tag, idx), done, 0);
      if (noise) begin
        vld_in = 1'($urandom);
        d_e0 = efx_t'($urandom);
        d_x0 = tx_t'($urandom);
      end
      if (vld_out) begin
        chk($sformatf("%s_rec%0d", tag, idx), dut_r, model(idx));
        if (idx == stall_at && rem > 0) begin
          rdy_out = 0;
          rem--;
          was_stall = 1;
        end else begin
          rdy_out = 1;
          idx++;
        end
      end else rdy_out = 1'($urandom);
      tick();
      cyc++;
    end
    vld_in = 0;
    rdy_out = 1;
    chk($sformatf("%s_count", tag), idx, n);
    chk($sformatf("%s_done", tag), done, 1);
    chk($sformatf("%s_end_vld", tag), vld_out, 0);
    chk($sformatf("%s_end_busy", tag), busy, 0);
    chk($sformatf("%s_end_rdy_in", tag), rdy_in, 1);
    tick();
    chk($sformatf("%s_done_once", tag), done, 0);
  endtask

  initial begin
    tick();
    chk("rst_rdy_in", rdy_in, 1);
    chk("rst_vld_out", vld_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_edge", o_e0, 0);
    rst_n = 1;
    tick();

    set_tri(10, 20, 30, 0, 16'sd256, 0, 0, 0);
    send(1, 2, 3, 3);
    collect("row", -1, 0, -1, 0);

    set_tri(5, 6, 7, 16'sd3, -16'sd2, 16'sd256, 16'sd512, 0);
    send(0, 1, 0, 1);
    collect("zseq", -1, 0, -1, 0);

    set_tri(100, -200, 300, 16'sd40, 16'sd70, -16'sd9, 16'sd11, 1234);
    send(2, 4, 6, 7);
    collect("stall", 1, 5, -1, 0);

    set_tri(1, 2, 3, 1, 1, 1, 1, 1);
    send(3, 1, 0, 0);
    chk("degen_done", done, 1);
    chk("degen_vld", vld_out, 0);
    chk("degen_rdy_in", rdy_in, 1);
    tick();
    chk("degen_done_once", done, 0);
    for (int i = 0; i < 3; i++) begin
      chk("degen_no_vld", vld_out, 0);
      tick();
    end

    set_tri(7, 8, 9, 16'sd12, 16'sd34, 16'sd5, 16'sd6, 77);
    send(0, 2, 0, 2);
    collect("abort", -1, 0, 2, 0);
    set_tri(-7, -8, -9, -16'sd12, 16'sd34, -16'sd5, 16'sd6, -77);
    send(5, 6, 9, 10);
    collect("post_abort", -1, 0, -1, 0);

    set_tri(1000, 2000, 3000, -16'sd128, 0, 0, 0, 0);
    send(4, 4, 5, 6);
    collect("negdx", -1, 0, -1, 0);

    for (int t = 0; t < 8; t++) begin
      int x0 = int'($urandom_range(0, 27));
      int y0 = int'($urandom_range(0, 28));
      int x1 = x0 + int'($urandom_range(0, 3));
      int y1 = y0 + int'($urandom_range(0, 2));
      int n = (x1 - x0 + 1) * (y1 - y0 + 1);
      set_tri(efx_t'($urandom), efx_t'($urandom), efx_t'($urandom), fx_t'($urandom), fx_t'($urandom),
              fx_t'($urandom), fx_t'($urandom), efx_t'($urandom));
      m_d[1] = '{x: fx_t'($urandom), y: fx_t'($urandom), z: fx_t'($urandom)};
      m_d[2] = '{x: fx_t'($urandom), y: fx_t'($urandom), z: fx_t'($urandom)};
      send(x0, x1, y0, y1);
      collect($sformatf("rnd%0d", t), int'($urandom_range(0, n - 1)), int'($urandom_range(0, 4)), -1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
